// File: rtl/fetch_pkg.sv
// Shared definitions for the picoMIPS fetch stage: FSM states and opcodes.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 6'h01;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_HALT = 6'h3F;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next program counter: hold, increment, or add a sign-extended relative offset.
// All arithmetic wraps modulo 2^PSIZE.
module pc_next #(
  parameter int PSIZE = 8,
  parameter int OFFW  = 8
) (
  input  logic [PSIZE-1:0] pc,
  input  logic [OFFW-1:0]  offset,
  input  logic             pc_incr,
  input  logic             pc_relbranch,
  output logic [PSIZE-1:0] next_pc
);

  // Wide enough to hold both the PC and the raw offset before truncation.
  localparam int W = (PSIZE > OFFW) ? PSIZE : OFFW;

  logic [W-1:0] offset_ext;

  // Sign-extend the offset, then keep only the PC-width bits.
  assign offset_ext = W'($signed(offset));

  // Select among the three PC update rules.
  always_comb begin
    // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
    next_pc = pc;
    if (pc_incr) begin
      if (pc_relbranch) next_pc = pc + offset_ext[PSIZE-1:0];
      else              next_pc = pc + PSIZE'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// picoMIPS instruction fetch stage: owns the PC, fetches over a req/valid
// handshake, holds the word in the instruction register until retire.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PSIZE    = 8,
  parameter int ISIZE    = 20,
  parameter int OFFW     = 8,
  parameter int RESET_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [PSIZE-1:0] mem_addr,
  output logic             mem_req,
  input  logic             mem_valid,
  input  logic [ISIZE-1:0] mem_rdata,
  output logic [ISIZE-1:0] instr,
  output logic [5:0]       opcode,
  output logic             instr_valid,
  input  logic             ex_ready,
  input  logic             pc_incr,
  input  logic             pc_relbranch,
  output logic [PSIZE-1:0] pc,
  output logic             halted
);

  fetch_state_t     state;
  logic [PSIZE-1:0] next_pc;

  assign mem_addr = pc;
  assign opcode   = instr[ISIZE-1 -: 6];

  pc_next #(
    .PSIZE (PSIZE),
    .OFFW  (OFFW)
  ) u_pc_next (
    .pc           (pc),
    .offset       (instr[OFFW-1:0]),
    .pc_incr      (pc_incr),
    .pc_relbranch (pc_relbranch),
    .next_pc      (next_pc)
  );

  // Fetch FSM with registered handshake outputs, instruction register and PC.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset) begin
      state       <= IDLE;
      pc          <= PSIZE'(RESET_PC);
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          mem_req <= 1'b1;
        end
        FETCH: begin
          if (mem_valid) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (ex_ready) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            if (opcode == OP_HALT) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state   <= FETCH;
              mem_req <= 1'b1;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and decoder-interface sanity checks.
  a_addr_stable: assert property (@(posedge clk)
    (mem_req && !mem_valid && !reset) |=> $stable(mem_addr));

  a_instr_stable: assert property (@(posedge clk)
    (instr_valid && !ex_ready && !reset) |=> $stable(instr));

  a_opcode_known: assert property (@(posedge clk)
    instr_valid |-> !$isunknown(opcode));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized instruction stream, compared against a transaction-level PC model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PSIZE    = 8;
  localparam int ISIZE    = 20;
  localparam int OFFW     = 8;
  localparam int RESET_PC = 0;
  localparam int PC_MOD   = 1 << PSIZE;

  logic             clk = 1'b0;
  logic             reset;
  logic [PSIZE-1:0] mem_addr;
  logic             mem_req;
  logic             mem_valid;
  logic [ISIZE-1:0] mem_rdata;
  logic [ISIZE-1:0] instr;
  logic [5:0]       opcode;
  logic             instr_valid;
  logic             ex_ready;
  logic             pc_incr;
  logic             pc_relbranch;
  logic [PSIZE-1:0] pc;
  logic             halted;

  fetch_unit #(
    .PSIZE    (PSIZE),
    .ISIZE    (ISIZE),
    .OFFW     (OFFW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_valid    (mem_valid),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .ex_ready     (ex_ready),
    .pc_incr      (pc_incr),
    .pc_relbranch (pc_relbranch),
    .pc           (pc),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ISIZE-1:0] prog [0:PC_MOD-1];
  int               model_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural PC rule: hold, +1, or + signed offset, modulo 2^PSIZE.
  function automatic int model_next(int cur, logic [ISIZE-1:0] w, bit incr, bit rel);
    int off;
    int n;
    off = int'(w[OFFW-1:0]);
    if (off >= (1 << (OFFW - 1))) off -= (1 << OFFW);
    if (!incr)    n = cur;
    else if (rel) n = cur + off;
    else          n = cur + 1;
    return ((n % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  // One full fetch/issue/retire transaction. Entry: first cycle of FETCH.
  // lat = cycles from first request to mem_valid; stall = ex_ready-low cycles.
  task automatic do_fetch(input int lat, input int stall, input bit incr, input bit rel);
    logic [ISIZE-1:0] w;
    bit               is_halt;
    w       = prog[model_pc];
    is_halt = (w[ISIZE-1 -: 6] == OP_HALT);
    check("fetch_req", mem_req, 1);
    check("fetch_addr", mem_addr, model_pc);
    mem_valid = 1'b0;
    for (int i = 1; i < lat; i++) begin
      mem_rdata = ISIZE'($urandom);
      tick();
      check("wait_req", mem_req, 1);
      check("wait_addr", mem_addr, model_pc);
      check("wait_ivalid", instr_valid, 0);
    end
    tick();
    check("valid_cycle_req", mem_req, 1);
    mem_valid = 1'b1;
    mem_rdata = w;
    tick();
    // Memory responses outside FETCH must be ignored.
    mem_valid = 1'($urandom);
    mem_rdata = ISIZE'($urandom);
    check("issue_ivalid", instr_valid, 1);
    check("issue_instr", instr, w);
    check("issue_opcode", opcode, w[ISIZE-1 -: 6]);
    check("issue_req", mem_req, 0);
    ex_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      mem_valid = 1'($urandom);
      mem_rdata = ISIZE'($urandom);
      check("stall_instr", instr, w);
      check("stall_ivalid", instr_valid, 1);
      check("stall_pc", pc, model_pc);
    end
    ex_ready     = 1'b1;
    pc_incr      = incr;
    pc_relbranch = rel;
    tick();
    ex_ready  = 1'b0;
    mem_valid = 1'b0;
    model_pc  = model_next(model_pc, w, incr, rel);
    check("retire_pc", pc, model_pc);
    check("retire_ivalid", instr_valid, 0);
    check("retire_req", mem_req, is_halt ? 0 : 1);
    check("retire_halted", halted, is_halt ? 1 : 0);
  endtask

  initial begin
    reset        = 1'b1;
    mem_valid    = 1'b1;
    mem_rdata    = '1;
    ex_ready     = 1'b0;
    pc_incr      = 1'b0;
    pc_relbranch = 1'b0;
    model_pc     = RESET_PC;

    for (int i = 0; i < PC_MOD; i++) prog[i] = {OP_ADD, 6'h00, 8'h00};
    prog[0] = {OP_ADD, 6'h00, 8'h05};
    prog[2] = {OP_ADD, 6'h00, 8'hFC};
    prog[6] = {OP_ADD, 6'h00, 8'hFC};

    // Reset with a spurious memory response present.
    tick();
    tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_req", mem_req, 0);
    check("rst_ivalid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_halted", halted, 0);
    reset     = 1'b0;
    mem_valid = 1'b0;
    check("idle_bubble_req", mem_req, 0);
    tick();

    // Back-to-back ADDs with 1-cycle memory.
    for (int i = 0; i < 4; i++) do_fetch(1, 0, 1'b1, 1'b0);
    check("pc_after_4", pc, 4);

    // Long memory latency, then a stalled issue.
    do_fetch(5, 0, 1'b1, 1'b0);
    do_fetch(1, 4, 1'b1, 1'b0);

    // Branch back to 2, branch by -4 to 0xFE, step across the top to 0x00.
    do_fetch(1, 0, 1'b1, 1'b1);
    check("branch_to_2", pc, 8'h02);
    do_fetch(2, 0, 1'b1, 1'b1);
    check("branch_to_fe", pc, 8'hFE);
    do_fetch(1, 0, 1'b1, 1'b0);
    do_fetch(1, 0, 1'b1, 1'b0);
    check("wrap_to_00", pc, 8'h00);

    // Hold (refetch same address), then branch +5.
    do_fetch(1, 1, 1'b0, 1'b0);
    check("hold_pc", pc, 8'h00);
    do_fetch(1, 0, 1'b1, 1'b1);
    check("branch_to_5", pc, 8'h05);

    // HALT at address 5: pc still advances, then fetch stops.
    prog[5] = {OP_HALT, 6'h00, 8'h00};
    do_fetch(2, 1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      mem_valid = 1'($urandom);
      mem_rdata = ISIZE'($urandom);
      tick();
      check("halt_req", mem_req, 0);
      check("halt_pc", pc, 6);
      check("halt_flag", halted, 1);
      check("halt_ivalid", instr_valid, 0);
    end

    // Reset leaves HALT and fetch resumes at RESET_PC.
    mem_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset    = 1'b0;
    model_pc = RESET_PC;
    check("unhalt_pc", pc, RESET_PC);
    check("unhalt_flag", halted, 0);
    check("unhalt_req", mem_req, 0);
    tick();

    // Randomized instruction stream (no HALT opcodes).
    for (int i = 0; i < PC_MOD; i++) begin
      logic [ISIZE-1:0] w;
      w = ISIZE'($urandom);
      if (w[ISIZE-1 -: 6] == OP_HALT) w[ISIZE-1 -: 6] = OP_ADDI;
      prog[i] = w;
    end
    for (int n = 0; n < 60; n++) begin
      do_fetch(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    // Reset during FETCH with mem_valid in the same cycle: reset wins.
    check("pre_reset_req", mem_req, 1);
    reset     = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = ISIZE'($urandom);
    tick();
    reset     = 1'b0;
    mem_valid = 1'b0;
    model_pc  = RESET_PC;
    check("rst_fetch_ivalid", instr_valid, 0);
    check("rst_fetch_instr", instr, 0);
    check("rst_fetch_pc", pc, RESET_PC);
    check("rst_fetch_idle_req", mem_req, 0);
    tick();
    check("rst_fetch_resume_req", mem_req, 1);
    check("rst_fetch_resume_addr", mem_addr, RESET_PC);
    do_fetch(1, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
